// File: rtl/spi_bit_counter_if.sv
// Command/status bundle between an SPI read/write FSM (master) and its
// bit/cycle counter (slave).
interface spi_bit_counter_if #(
  parameter int WIDTH = 5
);
  // No valid/ready: the FSM presents a command every clk cycle and HOLD is the idle code.
  // Status outputs are valid every cycle.
  logic [2:0]       cmd_i;
  logic [WIDTH-1:0] load_i;
  logic [WIDTH-1:0] tc_i;
  logic             tc_we_i;
  logic [WIDTH-1:0] cnt_o;
  logic             flag_o;
  logic             zero_o;
  logic             done_o;

  modport master (
    output cmd_i, load_i, tc_i, tc_we_i,
    input  cnt_o, flag_o, zero_o, done_o
  );

  modport slave (
    input  cmd_i, load_i, tc_i, tc_we_i,
    output cnt_o, flag_o, zero_o, done_o
  );
endinterface

// File: rtl/spi_bit_counter.sv
// Programmable up/down bit counter with load, optional auto-reload and
// terminal/zero/done status for the SPI engine FSMs.
module spi_bit_counter #(
  parameter int WIDTH       = 5,
  parameter int TC_DEFAULT  = 25,
  parameter bit AUTO_RELOAD = 1'b0
) (
  input  logic               clk_i,
  input  logic               rst_i,
  spi_bit_counter_if.slave   bus
);

  localparam logic [2:0] CMD_HOLD  = 3'b000;
  localparam logic [2:0] CMD_CLEAR = 3'b001;
  localparam logic [2:0] CMD_INC   = 3'b010;
  localparam logic [2:0] CMD_DEC   = 3'b011;
  localparam logic [2:0] CMD_LOAD  = 3'b100;

  localparam logic [WIDTH-1:0] TC_RESET = WIDTH'(TC_DEFAULT);
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO     = '0;

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] tc_q;
  logic             done_q;
  logic [WIDTH-1:0] cnt_d;
  logic             done_d;
  logic             at_tc;
  logic             at_zero;

  assign at_tc   = (cnt_q == tc_q);
  assign at_zero = (cnt_q == ZERO);

  // Next count is decided against the current tc_q, even when tc is being rewritten this cycle.
  always_comb begin
    cnt_d = cnt_q;
    case (bus.cmd_i)
      CMD_CLEAR: cnt_d = ZERO;
      CMD_LOAD:  cnt_d = bus.load_i;
      CMD_INC: begin
        if (at_tc) cnt_d = AUTO_RELOAD ? ZERO : tc_q;
        else       cnt_d = cnt_q + ONE;
      end
      CMD_DEC: begin
        if (at_zero) cnt_d = AUTO_RELOAD ? tc_q : ZERO;
        else         cnt_d = cnt_q - ONE;
      end
      default:   cnt_d = cnt_q;
    endcase
  end

  // done only marks an INC arriving at tc, never sitting on it or arriving by LOAD/DEC.
  always_comb begin
    done_d = (bus.cmd_i == CMD_INC) && (cnt_d == tc_q) && !at_tc;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= ZERO;
      tc_q   <= TC_RESET;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
      if (bus.tc_we_i) tc_q <= bus.tc_i;
    end
  end

  assign bus.cnt_o  = cnt_q;
  assign bus.flag_o = at_tc;
  assign bus.zero_o = at_zero;
  assign bus.done_o = done_q;

endmodule

// File: tb/tb_spi_bit_counter.sv
// Directed bench for spi_bit_counter: table of vectors against a non-reloading
// instance plus hand sequences for the auto-reload instance.
module tb_spi_bit_counter;

  localparam int W = 5;

  localparam logic [2:0] HOLD  = 3'b000;
  localparam logic [2:0] CLR   = 3'b001;
  localparam logic [2:0] INC   = 3'b010;
  localparam logic [2:0] DEC   = 3'b011;
  localparam logic [2:0] LOAD  = 3'b100;

  typedef struct {
    logic         rst;
    logic [2:0]   cmd;
    logic [W-1:0] load;
    logic [W-1:0] tc;
    logic         tc_we;
    logic [W-1:0] exp_cnt;
    logic         exp_flag;
    logic         exp_zero;
    logic         exp_done;
  } vec_t;

  logic clk;
  logic rst;
  int   tests;
  int   fails;
  vec_t vecs[$];

  // ---------------- clock / reset block ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  spi_bit_counter_if #(.WIDTH(W)) bus0 ();
  spi_bit_counter_if #(.WIDTH(W)) bus1 ();

  spi_bit_counter #(.WIDTH(W), .TC_DEFAULT(25), .AUTO_RELOAD(1'b0)) dut0 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus0)
  );

  spi_bit_counter #(.WIDTH(W), .TC_DEFAULT(25), .AUTO_RELOAD(1'b1)) dut1 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus1)
  );

  // ---------------- driver tasks ----------------
  // Both instances see identical stimulus; inputs change #1 after the edge.
  task automatic step(input logic r, input logic [2:0] c, input logic [W-1:0] ld,
                      input logic [W-1:0] t, input logic we);
    rst          = r;
    bus0.cmd_i   = c;
    bus0.load_i  = ld;
    bus0.tc_i    = t;
    bus0.tc_we_i = we;
    bus1.cmd_i   = c;
    bus1.load_i  = ld;
    bus1.tc_i    = t;
    bus1.tc_we_i = we;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic r, input logic [2:0] c, input logic [W-1:0] ld,
                     input logic [W-1:0] t, input logic we, input logic [W-1:0] ec,
                     input logic ef, input logic ez, input logic ed);
    vec_t v;
    v.rst = r; v.cmd = c; v.load = ld; v.tc = t; v.tc_we = we;
    v.exp_cnt = ec; v.exp_flag = ef; v.exp_zero = ez; v.exp_done = ed;
    vecs.push_back(v);
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input int idx, input logic [31:0] got,
                       input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s [%0d]: got %0d expected %0d", name, idx, got, exp);
    end
  endtask

  task automatic check0(input string tag, input int idx, input logic [W-1:0] ec,
                        input logic ef, input logic ez, input logic ed);
    check({tag, ".cnt"},  idx, 32'(bus0.cnt_o),  32'(ec));
    check({tag, ".flag"}, idx, 32'(bus0.flag_o), 32'(ef));
    check({tag, ".zero"}, idx, 32'(bus0.zero_o), 32'(ez));
    check({tag, ".done"}, idx, 32'(bus0.done_o), 32'(ed));
  endtask

  task automatic check1(input string tag, input int idx, input logic [W-1:0] ec,
                        input logic ef, input logic ez, input logic ed);
    check({tag, ".cnt"},  idx, 32'(bus1.cnt_o),  32'(ec));
    check({tag, ".flag"}, idx, 32'(bus1.flag_o), 32'(ef));
    check({tag, ".zero"}, idx, 32'(bus1.zero_o), 32'(ez));
    check({tag, ".done"}, idx, 32'(bus1.done_o), 32'(ed));
  endtask

  initial begin
    logic [W-1:0] c;
    logic [W-1:0] seq_ar [9];
    tests = 0;
    fails = 0;

    // ---- vector table for the non-reloading instance (tc starts at 25) ----
    add(1, HOLD, 0, 0, 0, 0, 0, 1, 0);                       // reset
    for (int i = 1; i <= 30; i++) begin                      // INC x30
      c = (i > 25) ? W'(25) : W'(i);
      add(0, INC, 0, 0, 0, c, c == 25, 0, i == 25);
    end
    add(0, LOAD, 5, 0, 0, 5, 0, 0, 0);                       // LOAD 5, DEC x7
    for (int i = 1; i <= 7; i++) begin
      c = (i > 5) ? W'(0) : W'(5 - i);
      add(0, DEC, 0, 0, 0, c, 0, c == 0, 0);
    end
    add(0, LOAD, 30, 0, 0, 30, 0, 0, 0);                     // above tc, wraps through 0
    add(0, INC, 0, 0, 0, 31, 0, 0, 0);
    add(0, INC, 0, 0, 0, 0, 0, 1, 0);
    add(0, INC, 0, 0, 0, 1, 0, 0, 0);
    add(0, INC, 0, 0, 0, 2, 0, 0, 0);
    for (int i = 3; i <= 25; i++)
      add(0, INC, 0, 0, 0, W'(i), i == 25, 0, i == 25);
    add(0, INC, 0, 0, 0, 25, 1, 0, 0);
    add(0, CLR, 0, 0, 0, 0, 0, 1, 0);                        // same-cycle tc write
    add(0, LOAD, 10, 0, 0, 10, 0, 0, 0);
    add(0, INC, 0, 11, 1, 11, 1, 0, 0);
    add(0, INC, 0, 0, 0, 11, 1, 0, 0);
    add(0, LOAD, 12, 0, 0, 12, 0, 0, 0);                     // DEC / LOAD landing on tc
    add(0, DEC, 0, 0, 0, 11, 1, 0, 0);
    add(0, LOAD, 11, 0, 0, 11, 1, 0, 0);
    add(0, HOLD, 0, 20, 1, 11, 0, 0, 0);                     // reset mid-count
    add(0, LOAD, 17, 0, 0, 17, 0, 0, 0);
    add(1, INC, 0, 5, 1, 0, 0, 1, 0);
    add(0, LOAD, 25, 0, 0, 25, 1, 0, 0);                     // tc back at 25
    add(0, 3'b101, 3, 0, 0, 25, 1, 0, 0);                    // undefined codes hold
    add(0, 3'b110, 3, 0, 0, 25, 1, 0, 0);
    add(0, 3'b111, 3, 0, 0, 25, 1, 0, 0);
    add(0, HOLD, 3, 0, 0, 25, 1, 0, 0);
    add(0, CLR, 0, 0, 1, 0, 1, 1, 0);                        // tc = 0 corner
    add(0, INC, 0, 0, 0, 0, 1, 1, 0);
    add(0, DEC, 0, 0, 0, 0, 1, 1, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].cmd, vecs[i].load, vecs[i].tc, vecs[i].tc_we);
      check0("vec", i, vecs[i].exp_cnt, vecs[i].exp_flag, vecs[i].exp_zero, vecs[i].exp_done);
    end

    // ---- auto-reload instance: tc=3, INC x9 ----
    step(1, HOLD, 0, 0, 0);
    check1("ar_reset", 0, 0, 0, 1, 0);
    step(0, HOLD, 0, 3, 1);
    check1("ar_tcwr", 0, 0, 0, 1, 0);
    seq_ar = '{W'(1), W'(2), W'(3), W'(0), W'(1), W'(2), W'(3), W'(0), W'(1)};
    for (int i = 0; i < 9; i++) begin
      step(0, INC, 0, 0, 0);
      check1("ar_inc", i, seq_ar[i], seq_ar[i] == 3, seq_ar[i] == 0, seq_ar[i] == 3);
    end
    step(0, DEC, 0, 0, 0);
    check1("ar_dec", 0, 0, 0, 1, 0);
    step(0, DEC, 0, 0, 0);                                   // underflow reloads tc
    check1("ar_dec", 1, 3, 1, 0, 0);
    step(0, DEC, 0, 0, 0);
    check1("ar_dec", 2, 2, 0, 0, 0);
    step(0, CLR, 0, 0, 1);                                   // tc = 0 with reload
    check1("ar_tc0", 0, 0, 1, 1, 0);
    step(0, INC, 0, 0, 0);
    check1("ar_tc0", 1, 0, 1, 1, 0);
    step(0, INC, 0, 0, 0);
    check1("ar_tc0", 2, 0, 1, 1, 0);

    // ---- final report ----
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/spi_bit_counter.md
Name: spi_bit_counter

Overview:
- Parametrised cycle/bit counter for the SPI engines. It counts dclk edges or bits under FSM command, against a runtime-programmable terminal count.
- Generalises the fixed 5-bit, fixed-25 write counter with these additions: configurable width, up/down counting, parallel load, optional auto-reload, and status flags (terminal, zero, single-cycle done pulse).
- Sits beside the SPI read/write FSMs. The FSM drives cmd_i each clk_i cycle and sequences on flag_o/done_o.

Parameters:
- WIDTH, 5, counter and terminal-count width in bits (≥2).
- TC_DEFAULT, 25, terminal-count register value after reset (must be < 2^WIDTH).
- AUTO_RELOAD, 0, 0 = INC stops at terminal count; 1 = INC at terminal count wraps to 0 and DEC at 0 wraps to tc.

Ports:
- clk_i  input  1  system clock, all state on rising edge.
- rst_i  input  1  synchronous active-high reset.
- cmd_i  input  3  000 HOLD, 001 CLEAR, 010 INC, 011 DEC, 100 LOAD, 101–111 HOLD.
- load_i  input  WIDTH  value written to counter on LOAD.
- tc_i  input  WIDTH  new terminal count.
- tc_we_i  input  1  write enable for terminal-count register.
- cnt_o  output  WIDTH  current count (registered).
- flag_o  output  1  cnt_o == tc register (combinational from registers).
- zero_o  output  1  cnt_o == 0.
- done_o  output  1  one-cycle registered pulse, first cycle cnt_o reaches tc via INC.

Behaviour:
- Reset: the only reset is synchronous, on rst_i high at a clk_i edge. Results: cnt=0, tc=TC_DEFAULT, done_o=0. Consequently zero_o=1 and flag_o=(TC_DEFAULT==0). rst_i overrides every command and tc_we_i, including mid-count.
- Registers: cnt_q (WIDTH), tc_q (WIDTH), done_q (1). No other state.
- Next-count mux, evaluated against the current cnt_q/tc_q:
  - HOLD: cnt_q.
  - CLEAR: 0.
  - LOAD: load_i (may exceed tc_q).
  - INC, cnt_q == tc_q:
    - AUTO_RELOAD=0: hold at tc_q.
    - AUTO_RELOAD=1: 0.
  - INC, otherwise: cnt_q+1 modulo 2^WIDTH. A counter above tc_q counts up to 2^WIDTH-1 and then wraps to 0. It stops at tc_q only when reached exactly.
  - DEC, cnt_q == 0:
    - AUTO_RELOAD=0: hold at 0 (no underflow).
    - AUTO_RELOAD=1: tc_q.
  - DEC, otherwise: cnt_q-1.
- Terminal-count register: when tc_we_i=1, tc_q <= tc_i at the edge.
  - Independent of cmd_i; both take effect in the same cycle.
  - The mux, flag_o and done_o logic for that cycle use the old tc_q.
- done_q is set at an edge iff all of the following hold: cmd_i==INC, next count == tc_q, and cnt_q != tc_q. It clears on every other edge.
  - Never more than one cycle wide for a single approach.
  - AUTO_RELOAD=0 with INC held at terminal: done_o=0 after the first cycle.
  - AUTO_RELOAD=1, tc=N: done_o pulses once per N+1 INC cycles.
  - LOAD or DEC landing on tc does not assert done_o. flag_o still asserts.
- Latency:
  - cnt_o, done_o: 1 cycle after command.
  - flag_o, zero_o: same cycle as cnt_o/tc_q change.
- tc_q=0 corner case:
  - flag_o and zero_o both high at cnt=0.
  - INC at 0 with AUTO_RELOAD=0: holds 0, no done.
  - INC at 0 with AUTO_RELOAD=1: stays 0, no done, because cnt_q already equals tc_q.
- Undefined cmd codes behave exactly as HOLD. No X propagation from unused codes.
- Arithmetic is unsigned WIDTH-bit. No carry/borrow output.

Test Plan:
- Defaults (WIDTH=5, TC_DEFAULT=25, AUTO_RELOAD=0): reset, then INC for 30 cycles -> cnt_o 1..25 and then holds 25. flag_o high from cnt=25. done_o high exactly one cycle, the cycle cnt_o first shows 25. zero_o low after the first INC.
- AUTO_RELOAD=1, tc_we_i=1 with tc_i=3, then INC ×9 -> cnt_o sequence 1,2,3,0,1,2,3,0,1. done_o pulses at each cnt_o=3 (twice).
- LOAD 5, then DEC ×7 (AUTO_RELOAD=0) -> cnt_o 4,3,2,1,0,0,0. zero_o high from first 0. done_o never asserts.
- WIDTH=5: LOAD 30 with tc=25, then INC ×4 -> cnt_o 31, 0, 1, 2. No done_o. Then counting continues to 25 with a single done_o pulse.
- Same-cycle write: cnt=10, tc=25. In one cycle apply INC with tc_we_i=1, tc_i=11 -> cnt_o=11, done_o=0 (old tc used), flag_o=1 next cycle. A further INC holds at 11 with no done_o.
- Reset mid-operation: at cnt=17 with tc previously written to 20, assert rst_i together with INC and tc_we_i -> next cycle cnt_o=0, tc_q=25, done_o=0, zero_o=1.
